// File: rtl/reg_access_seq_if.sv
// Bundles the request, response and register-file port signals of the operand-access sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding decode/file logic.
`timescale 1ns/1ps

interface reg_access_seq_if #(
  parameter int XLEN          = 32,
  parameter int REG_IDX_WIDTH = 5
) ();

  logic                     req_valid;
  logic                     req_ready;
  logic                     rs1_en;
  logic [REG_IDX_WIDTH-1:0] rs1_idx;
  logic                     rs2_en;
  logic [REG_IDX_WIDTH-1:0] rs2_idx;
  logic                     rd_we;
  logic [REG_IDX_WIDTH-1:0] rd_idx;
  logic [XLEN-1:0]          rd_data;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [XLEN-1:0]          rs1_data;
  logic [XLEN-1:0]          rs2_data;

  logic                     rf_op;
  logic                     rf_rw;
  logic [REG_IDX_WIDTH-1:0] rf_reg_idx;
  logic [XLEN-1:0]          rf_data_w;
  logic [XLEN-1:0]          rf_data_r;

  modport slave (
    input  req_valid, rs1_en, rs1_idx, rs2_en, rs2_idx, rd_we, rd_idx, rd_data,
    input  resp_ready, rf_data_r,
    output req_ready, resp_valid, rs1_data, rs2_data,
    output rf_op, rf_rw, rf_reg_idx, rf_data_w
  );

  modport master (
    output req_valid, rs1_en, rs1_idx, rs2_en, rs2_idx, rd_we, rd_idx, rd_data,
    output resp_ready, rf_data_r,
    input  req_ready, resp_valid, rs1_data, rs2_data,
    input  rf_op, rf_rw, rf_reg_idx, rf_data_w
  );

endinterface

// File: rtl/reg_access_seq.sv
// Operand-access sequencer: serialises an optional rd write-back and up to two source reads
// onto a single-port register file, then returns both operands together on one response.
`timescale 1ns/1ps

module reg_access_seq #(
  parameter int XLEN          = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  reg_access_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic                     req_ready_q;
  logic                     resp_valid_q;
  logic [XLEN-1:0]          rs1_data_q;
  logic [XLEN-1:0]          rs2_data_q;

  logic                     rs1_en_q;
  logic [REG_IDX_WIDTH-1:0] rs1_idx_q;
  logic                     rs2_en_q;
  logic [REG_IDX_WIDTH-1:0] rs2_idx_q;
  logic                     rd_we_q;
  logic [REG_IDX_WIDTH-1:0] rd_idx_q;
  logic [XLEN-1:0]          rd_data_q;

  logic                     req_fire;
  logic                     need_wr_in, need_rd1_in, need_rd2_in;
  logic                     need_rd1_q, need_rd2_q;

  logic                     rf_op;
  logic                     rf_rw;
  logic [REG_IDX_WIDTH-1:0] rf_reg_idx;
  logic [XLEN-1:0]          rf_data_w;

  // Walks the fixed WR -> RD1 -> RD2 -> RESP order, skipping any access that is not needed.
  function automatic state_e first_needed(input logic wr, input logic rd1, input logic rd2);
    if (wr)       return S_WR;
    else if (rd1) return S_RD1;
    else if (rd2) return S_RD2;
    else          return S_RESP;
  endfunction

  // Accesses to x0 never reach the file: writes are dropped, reads return zero.
  assign need_wr_in  = bus.rd_we  && (bus.rd_idx  != '0);
  assign need_rd1_in = bus.rs1_en && (bus.rs1_idx != '0);
  assign need_rd2_in = bus.rs2_en && (bus.rs2_idx != '0);
  assign need_rd1_q  = rs1_en_q   && (rs1_idx_q   != '0);
  assign need_rd2_q  = rs2_en_q   && (rs2_idx_q   != '0);

  assign req_fire = (state_q == S_IDLE) && bus.req_valid && req_ready_q;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_fire) state_d = first_needed(need_wr_in, need_rd1_in, need_rd2_in);
      S_WR:   state_d = first_needed(1'b0, need_rd1_q, need_rd2_q);
      S_RD1:  state_d = first_needed(1'b0, 1'b0, need_rd2_q);
      S_RD2:  state_d = S_RESP;
      S_RESP: if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      rs1_en_q     <= 1'b0;
      rs1_idx_q    <= '0;
      rs2_en_q     <= 1'b0;
      rs2_idx_q    <= '0;
      rd_we_q      <= 1'b0;
      rd_idx_q     <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      // Handshake flags are registered from the next state so they line up with it.
      req_ready_q  <= (state_d == S_IDLE);
      resp_valid_q <= (state_d == S_RESP);

      unique case (state_q)
        S_IDLE: begin
          if (req_fire) begin
            rs1_en_q   <= bus.rs1_en;
            rs1_idx_q  <= bus.rs1_idx;
            rs2_en_q   <= bus.rs2_en;
            rs2_idx_q  <= bus.rs2_idx;
            rd_we_q    <= bus.rd_we;
            rd_idx_q   <= bus.rd_idx;
            rd_data_q  <= bus.rd_data;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
          end
        end
        S_RD1:   rs1_data_q <= bus.rf_data_r;
        S_RD2:   rs2_data_q <= bus.rf_data_r;
        default: ;
      endcase
    end
  end

  // Decoded straight from state so an asynchronous reset drops rf_op before the file's negedge sample.
  always_comb begin
    rf_op      = 1'b0;
    rf_rw      = 1'b0;
    rf_reg_idx = '0;
    rf_data_w  = '0;
    unique case (state_q)
      S_WR: begin
        rf_op      = 1'b1;
        rf_rw      = 1'b1;
        rf_reg_idx = rd_idx_q;
        rf_data_w  = rd_data_q;
      end
      S_RD1: begin
        rf_op      = 1'b1;
        rf_reg_idx = rs1_idx_q;
      end
      S_RD2: begin
        rf_op      = 1'b1;
        rf_reg_idx = rs2_idx_q;
      end
      default: ;
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.rs1_data   = rs1_data_q;
  assign bus.rs2_data   = rs2_data_q;
  assign bus.rf_op      = rf_op;
  assign bus.rf_rw      = rf_rw;
  assign bus.rf_reg_idx = rf_reg_idx;
  assign bus.rf_data_w  = rf_data_w;

endmodule

// File: tb/tb_reg_access_seq.sv
// Self-checking bench for reg_access_seq: a negedge-sampling register file model on the rf port,
// and a request-level reference that predicts operands, latency and file traffic per request.
`timescale 1ns/1ps

module tb_reg_access_seq;

  localparam int XLEN = 32;
  localparam int IW   = 5;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  reg_access_seq_if #(.XLEN(XLEN), .REG_IDX_WIDTH(IW)) bus ();

  reg_access_seq #(.XLEN(XLEN), .REG_IDX_WIDTH(IW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] init_val(input int i);
    if (i == 0)      return '0;
    else if (i == 2) return 32'd1;
    else if (i == 3) return 32'd2;
    else             return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Register file model: samples op/rw/idx on the negedge, x0 hardwired to zero.
  logic [XLEN-1:0] file_regs [32];
  int wr_cnt = 0;
  int rd_cnt = 0;

  initial begin
    for (int i = 0; i < 32; i++) file_regs[i] = init_val(i);
    bus.rf_data_r = '0;
    forever begin
      @(negedge sys_clk);
      if (bus.rf_op === 1'b1) begin
        if (bus.rf_rw === 1'b1) begin
          if (bus.rf_reg_idx != '0) file_regs[bus.rf_reg_idx] = bus.rf_data_w;
          wr_cnt++;
        end else begin
          bus.rf_data_r = file_regs[bus.rf_reg_idx];
          rd_cnt++;
        end
      end
    end
  end

  // Architectural view of the register contents as the requests should leave them.
  logic [XLEN-1:0] ref_regs [32];

  task automatic drive_junk();
    bus.req_valid = 1'b1;
    bus.rs1_en    = 1'($urandom);
    bus.rs1_idx   = IW'($urandom);
    bus.rs2_en    = 1'($urandom);
    bus.rs2_idx   = IW'($urandom);
    bus.rd_we     = 1'($urandom);
    bus.rd_idx    = IW'($urandom);
    bus.rd_data   = $urandom;
  endtask

  task automatic run_req(input string tag, input logic we, input logic [IW-1:0] rd,
                         input logic [XLEN-1:0] wd, input logic e1, input logic [IW-1:0] i1,
                         input logic e2, input logic [IW-1:0] i2, input int hold);
    logic [XLEN-1:0] exp1, exp2;
    int exp_wr, exp_rd, exp_lat, lat, n, wr0, rd0;
    logic busy_ready, unstable;

    exp_wr = (we && rd != 0) ? 1 : 0;
    if (exp_wr == 1) ref_regs[rd] = wd;
    exp1    = (e1 && i1 != 0) ? ref_regs[i1] : '0;
    exp2    = (e2 && i2 != 0) ? ref_regs[i2] : '0;
    exp_rd  = ((e1 && i1 != 0) ? 1 : 0) + ((e2 && i2 != 0) ? 1 : 0);
    exp_lat = 1 + exp_wr + exp_rd;

    @(negedge sys_clk);
    bus.req_valid = 1'b1;
    bus.rd_we = we;  bus.rd_idx = rd;  bus.rd_data = wd;
    bus.rs1_en = e1; bus.rs1_idx = i1;
    bus.rs2_en = e2; bus.rs2_idx = i2;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, ":req_ready"}, 32'(bus.req_ready), 32'd1);
    wr0 = wr_cnt;
    rd0 = rd_cnt;

    @(posedge sys_clk);
    #1;
    drive_junk();

    busy_ready = 1'b0;
    lat = 1;
    @(negedge sys_clk);
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      if (bus.req_ready !== 1'b0) busy_ready = 1'b1;
      @(negedge sys_clk);
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":rs1_data"}, bus.rs1_data, exp1);
    check({tag, ":rs2_data"}, bus.rs2_data, exp2);
    check({tag, ":rf_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    check({tag, ":rf_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));

    unstable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (bus.req_ready !== 1'b0) busy_ready = 1'b1;
      @(negedge sys_clk);
      if (bus.resp_valid !== 1'b1 || bus.rs1_data !== exp1 || bus.rs2_data !== exp2 || bus.rf_op !== 1'b0)
        unstable = 1'b1;
    end
    if (bus.req_ready !== 1'b0) busy_ready = 1'b1;
    check({tag, ":busy_ready"}, 32'(busy_ready), 32'd0);
    check({tag, ":resp_hold"}, 32'(unstable), 32'd0);

    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b0;
    @(posedge sys_clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge sys_clk);
    check({tag, ":post_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, ":post_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] rd, i1, i2;

    bus.req_valid  = 1'b0;
    bus.rs1_en     = 1'b0;
    bus.rs1_idx    = '0;
    bus.rs2_en     = 1'b0;
    bus.rs2_idx    = '0;
    bus.rd_we      = 1'b0;
    bus.rd_idx     = '0;
    bus.rd_data    = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);

    repeat (3) @(negedge sys_clk);
    check("reset:req_ready", 32'(bus.req_ready), 32'd1);
    check("reset:resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset:rs1_data", bus.rs1_data, '0);
    check("reset:rs2_data", bus.rs2_data, '0);
    check("reset:rf_op", 32'(bus.rf_op), 32'd0);
    check("reset:rf_rw", 32'(bus.rf_rw), 32'd0);
    check("reset:rf_reg_idx", 32'(bus.rf_reg_idx), 32'd0);
    check("reset:rf_data_w", bus.rf_data_w, '0);
    sys_rst_n = 1'b1;

    run_req("t1_read2",  1'b0, 5'd0, 32'h0,         1'b1, 5'd2, 1'b1, 5'd3, 0);
    run_req("t2_fwd",    1'b1, 5'd5, 32'hDEADBEEF,  1'b1, 5'd5, 1'b1, 5'd0, 1);
    run_req("t3_x0",     1'b1, 5'd0, 32'h12345678,  1'b0, 5'd4, 1'b0, 5'd6, 0);
    run_req("t4_stall",  1'b1, 5'd9, 32'hA5A5_0F0F, 1'b1, 5'd9, 1'b1, 5'd2, 5);

    // Reset lands while WR is on the port, before the file's negedge sample.
    @(negedge sys_clk);
    bus.req_valid = 1'b1;
    bus.rd_we = 1'b1;  bus.rd_idx = 5'd7; bus.rd_data = 32'hCAFEF00D;
    bus.rs1_en = 1'b0; bus.rs1_idx = '0;
    bus.rs2_en = 1'b0; bus.rs2_idx = '0;
    @(posedge sys_clk);
    #1;
    bus.req_valid = 1'b0;
    check("t5:wr_op", 32'(bus.rf_op), 32'd1);
    check("t5:wr_rw", 32'(bus.rf_rw), 32'd1);
    check("t5:wr_idx", 32'(bus.rf_reg_idx), 32'd7);
    sys_rst_n = 1'b0;
    #1;
    check("t5:rst_op", 32'(bus.rf_op), 32'd0);
    check("t5:rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check("t5:x7_unchanged", file_regs[7], ref_regs[7]);
    @(negedge sys_clk);
    check("t5:req_ready", 32'(bus.req_ready), 32'd1);
    run_req("t5_readback", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 0);

    for (int k = 0; k < 40; k++) begin
      rd = ($urandom_range(0, 3) == 0) ? IW'(0) : IW'($urandom);
      i1 = ($urandom_range(0, 2) == 0) ? rd : IW'($urandom);
      i2 = ($urandom_range(0, 3) == 0) ? IW'(0) : IW'($urandom);
      run_req($sformatf("rand%0d", k), 1'($urandom), rd, $urandom,
              1'($urandom), i1, 1'($urandom), i2, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
